// File: rtl/risc_seq_controller.sv
// Instruction register, decoder and multi-cycle controller for the Simple RISC Machine.
// Sequences register-file, A/B/C load, ALU and status strobes; counts retired instructions.
module risc_seq_controller #(
    parameter int DATA_W   = 16,
    parameter bit FAST_MOV = 1'b0,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s,
    input  logic              load,
    input  logic [15:0]       in,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic              write,
    output logic [1:0]        vsel,
    output logic              loada,
    output logic              loadb,
    output logic              asel,
    output logic              bsel,
    output logic              loadc,
    output logic              loads,
    output logic [1:0]        shift,
    output logic [1:0]        ALUop,
    output logic [DATA_W-1:0] sximm8,
    output logic [DATA_W-1:0] sximm5,
    output logic              w,
    output logic              illegal,
    output logic [CNT_W-1:0]  instr_count
);

    typedef enum logic [2:0] {
        S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WRITE_REG, S_WRITE_IMM
    } state_t;

    state_t      state, next_state;
    logic [15:0] ir;
    logic        retire;

    logic [2:0] opcode, rn, rd, rm;
    logic [1:0] op;
    logic       is_movi, is_movr, is_alu, is_cmp, is_mvn, is_legal;

    assign opcode   = ir[15:13];
    assign op       = ir[12:11];
    assign rn       = ir[10:8];
    assign rd       = ir[7:5];
    assign rm       = ir[2:0];
    assign is_movi  = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr  = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu   = (opcode == 3'b101);
    assign is_cmp   = is_alu && (op == 2'b01);
    assign is_mvn   = is_alu && (op == 2'b11);
    assign is_legal = is_movi || is_movr || is_alu;

    assign shift  = ir[4:3];
    assign sximm8 = DATA_W'($signed(ir[7:0]));
    assign sximm5 = DATA_W'($signed(ir[4:0]));
    assign bsel   = 1'b0;
    assign w      = (state == S_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_WAIT;
            ir          <= '0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= next_state;
            // Loads are only accepted while idle, so a busy instruction cannot be corrupted.
            if (state == S_WAIT && load)
                ir <= in;
            if (state == S_WAIT && s)
                illegal <= 1'b0;
            else if (state == S_DECODE && !is_legal)
                illegal <= 1'b1;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    // retire marks the last cycle of a legal instruction, i.e. the edge back into WAIT.
    always_comb begin
        next_state = state;
        readnum    = 3'd0;
        writenum   = 3'd0;
        write      = 1'b0;
        vsel       = 2'b00;
        loada      = 1'b0;
        loadb      = 1'b0;
        asel       = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        ALUop      = 2'b00;
        retire     = 1'b0;
        case (state)
            S_WAIT: begin
                if (s)
                    next_state = S_DECODE;
            end
            S_DECODE: begin
                if (is_movi && FAST_MOV) begin
                    writenum   = rn;
                    vsel       = 2'b10;
                    write      = 1'b1;
                    retire     = 1'b1;
                    next_state = S_WAIT;
                end else if (is_movi)
                    next_state = S_WRITE_IMM;
                else if (is_movr || is_mvn)
                    next_state = S_GET_B;
                else if (is_alu)
                    next_state = S_GET_A;
                else
                    next_state = S_WAIT;
            end
            S_GET_A: begin
                readnum    = rn;
                loada      = 1'b1;
                next_state = S_GET_B;
            end
            S_GET_B: begin
                readnum    = rm;
                loadb      = 1'b1;
                next_state = S_EXEC;
            end
            S_EXEC: begin
                loadc = 1'b1;
                ALUop = is_alu ? op : 2'b00;
                asel  = is_movr || is_mvn;
                loads = is_cmp;
                if (is_cmp) begin
                    retire     = 1'b1;
                    next_state = S_WAIT;
                end else
                    next_state = S_WRITE_REG;
            end
            S_WRITE_REG: begin
                writenum   = rd;
                write      = 1'b1;
                retire     = 1'b1;
                next_state = S_WAIT;
            end
            S_WRITE_IMM: begin
                writenum   = rn;
                vsel       = 2'b10;
                write      = 1'b1;
                retire     = 1'b1;
                next_state = S_WAIT;
            end
            default: next_state = S_WAIT;
        endcase
    end

endmodule

// File: tb/tb_risc_seq_controller.sv
// Bench for risc_seq_controller: instance 0 uses defaults, instance 1 uses FAST_MOV=1, CNT_W=2.
// A per-instruction schedule model predicts every output on every cycle.
module tb_risc_seq_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  reset, s, load;
    logic [15:0] in_w [2];

    typedef struct packed {
        logic       w;
        logic [2:0] readnum, writenum;
        logic       write;
        logic [1:0] vsel;
        logic       loada, loadb, asel, bsel, loadc, loads;
        logic [1:0] aluop;
    } strobe_t;

    typedef struct packed {
        strobe_t     st;
        logic [1:0]  shift;
        logic [15:0] sximm8, sximm5;
        logic        illegal;
        logic [7:0]  count;
    } obs_t;

    localparam strobe_t IDLE = '{w: 1'b1, default: '0};

    logic [2:0]  d0_readnum, d0_writenum, d1_readnum, d1_writenum;
    logic [1:0]  d0_vsel, d0_shift, d0_aluop, d1_vsel, d1_shift, d1_aluop;
    logic        d0_write, d0_loada, d0_loadb, d0_asel, d0_bsel, d0_loadc, d0_loads, d0_w, d0_illegal;
    logic        d1_write, d1_loada, d1_loadb, d1_asel, d1_bsel, d1_loadc, d1_loads, d1_w, d1_illegal;
    logic [15:0] d0_sximm8, d0_sximm5, d1_sximm8, d1_sximm5;
    logic [7:0]  d0_count;
    logic [1:0]  d1_count;

    risc_seq_controller #(.DATA_W(16), .FAST_MOV(1'b0), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset[0]), .s(s[0]), .load(load[0]), .in(in_w[0]),
        .readnum(d0_readnum), .writenum(d0_writenum), .write(d0_write), .vsel(d0_vsel),
        .loada(d0_loada), .loadb(d0_loadb), .asel(d0_asel), .bsel(d0_bsel),
        .loadc(d0_loadc), .loads(d0_loads), .shift(d0_shift), .ALUop(d0_aluop),
        .sximm8(d0_sximm8), .sximm5(d0_sximm5), .w(d0_w), .illegal(d0_illegal),
        .instr_count(d0_count));

    risc_seq_controller #(.DATA_W(16), .FAST_MOV(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset[1]), .s(s[1]), .load(load[1]), .in(in_w[1]),
        .readnum(d1_readnum), .writenum(d1_writenum), .write(d1_write), .vsel(d1_vsel),
        .loada(d1_loada), .loadb(d1_loadb), .asel(d1_asel), .bsel(d1_bsel),
        .loadc(d1_loadc), .loads(d1_loads), .shift(d1_shift), .ALUop(d1_aluop),
        .sximm8(d1_sximm8), .sximm5(d1_sximm5), .w(d1_w), .illegal(d1_illegal),
        .instr_count(d1_count));

    obs_t act [2];
    always_comb begin
        act[0] = '{st: '{w: d0_w, readnum: d0_readnum, writenum: d0_writenum, write: d0_write,
                         vsel: d0_vsel, loada: d0_loada, loadb: d0_loadb, asel: d0_asel,
                         bsel: d0_bsel, loadc: d0_loadc, loads: d0_loads, aluop: d0_aluop},
                   shift: d0_shift, sximm8: d0_sximm8, sximm5: d0_sximm5,
                   illegal: d0_illegal, count: d0_count};
        act[1] = '{st: '{w: d1_w, readnum: d1_readnum, writenum: d1_writenum, write: d1_write,
                         vsel: d1_vsel, loada: d1_loada, loadb: d1_loadb, asel: d1_asel,
                         bsel: d1_bsel, loadc: d1_loadc, loads: d1_loads, aluop: d1_aluop},
                   shift: d1_shift, sximm8: d1_sximm8, sximm5: d1_sximm5,
                   illegal: d1_illegal, count: {6'd0, d1_count}};
    end

    // Model state: per instance, the remaining cycles of the running instruction.
    strobe_t     sched [2][$];
    logic [15:0] m_ir [2];
    logic        m_illegal [2];
    logic        m_legal [2];
    logic [7:0]  m_count [2];
    int          tests = 0;
    int          fails = 0;
    bit          chk_en = 1'b0;
    obs_t        trace [$];

    task automatic build_schedule(input int d);
        logic [15:0] ir;
        logic        movi, movr, alu, mvn;
        strobe_t     e;
        ir   = m_ir[d];
        movi = (ir[15:11] == 5'b11010);
        movr = (ir[15:11] == 5'b11000);
        alu  = (ir[15:13] == 3'b101);
        mvn  = alu && (ir[12:11] == 2'b11);
        m_legal[d] = movi || movr || alu;
        e = '0;
        if (movi && d == 1) begin
            e.write = 1'b1; e.writenum = ir[10:8]; e.vsel = 2'b10;
            sched[d].push_back(e);
            return;
        end
        sched[d].push_back(e);
        if (movi) begin
            e = '0; e.write = 1'b1; e.writenum = ir[10:8]; e.vsel = 2'b10;
            sched[d].push_back(e);
        end else if (movr || mvn) begin
            e = '0; e.readnum = ir[2:0]; e.loadb = 1'b1; sched[d].push_back(e);
            e = '0; e.loadc = 1'b1; e.asel = 1'b1; e.aluop = movr ? 2'b00 : 2'b11;
            sched[d].push_back(e);
            e = '0; e.write = 1'b1; e.writenum = ir[7:5]; sched[d].push_back(e);
        end else if (alu) begin
            e = '0; e.readnum = ir[10:8]; e.loada = 1'b1; sched[d].push_back(e);
            e = '0; e.readnum = ir[2:0]; e.loadb = 1'b1; sched[d].push_back(e);
            e = '0; e.loadc = 1'b1; e.aluop = ir[12:11]; e.loads = (ir[12:11] == 2'b01);
            sched[d].push_back(e);
            if (ir[12:11] != 2'b01) begin
                e = '0; e.write = 1'b1; e.writenum = ir[7:5]; sched[d].push_back(e);
            end
        end
    endtask

    task automatic model_step(input int d);
        if (reset[d]) begin
            sched[d].delete();
            m_ir[d] = '0; m_illegal[d] = 1'b0; m_count[d] = '0;
        end else if (sched[d].size() == 0) begin
            if (load[d]) m_ir[d] = in_w[d];
            if (s[d]) begin
                m_illegal[d] = 1'b0;
                build_schedule(d);
            end
        end else begin
            void'(sched[d].pop_front());
            if (sched[d].size() == 0) begin
                if (m_legal[d]) m_count[d] = (m_count[d] + 8'd1) & ((d == 0) ? 8'hFF : 8'h03);
                else m_illegal[d] = 1'b1;
            end
        end
    endtask

    function automatic obs_t model_obs(input int d);
        obs_t e;
        e.st      = (sched[d].size() != 0) ? sched[d][0] : IDLE;
        e.st.w    = (sched[d].size() == 0);
        e.shift   = m_ir[d][4:3];
        e.sximm8  = {{8{m_ir[d][7]}}, m_ir[d][7:0]};
        e.sximm5  = {{11{m_ir[d][4]}}, m_ir[d][4:0]};
        e.illegal = m_illegal[d];
        e.count   = m_count[d];
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        model_step(0);
        model_step(1);
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                obs_t e;
                e = model_obs(d);
                tests++;
                if (act[d] !== e) begin
                    fails++;
                    $display("FAIL model dut%0d t=%0t: got %h expected %h", d, $time, act[d], e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Starts one instruction and records every w-low cycle into trace.
    task automatic run(input int d, input logic [15:0] word, input bit busy_load);
        bit done;
        trace.delete();
        done = 1'b0;
        @(negedge clk); #1;
        load[d] = 1'b1; in_w[d] = word; s[d] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (act[d].st.w) begin
                done = 1'b1;
                break;
            end
            trace.push_back(act[d]);
            #1;
            s[d] = 1'b0; load[d] = busy_load;
            if (busy_load) in_w[d] = 16'hD0FF;
        end
        #1;
        s[d] = 1'b0; load[d] = 1'b0;
        if (!done) begin
            tests++; fails++;
            $display("FAIL timeout dut%0d word %h", d, word);
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 4))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2, 3: r[15:13] = 3'b101;
            default: ;
        endcase
        return r;
    endfunction

    initial begin
        logic [7:0] loads_seen, write_seen;
        reset = 2'b11; s = 2'b00; load = 2'b00; in_w[0] = '0; in_w[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset_w", act[0].st.w, 1);
        chk("reset_count", act[0].count, 0);
        chk("reset_readnum", act[0].st.readnum, 0);
        #1 reset = 2'b00;

        run(0, 16'hD007, 1'b0);
        chk("movi_len", trace.size(), 2);
        chk("movi_writenum", trace[1].st.writenum, 0);
        chk("movi_vsel", trace[1].st.vsel, 2'b10);
        chk("movi_write", trace[1].st.write, 1);
        chk("movi_sximm8", trace[1].sximm8, 16'h0007);
        chk("movi_count", act[0].count, 1);

        run(0, 16'hA148, 1'b0);
        chk("add_len", trace.size(), 5);
        chk("add_geta_rd", trace[1].st.readnum, 1);
        chk("add_getb_rd", trace[2].st.readnum, 0);
        chk("add_shift", trace[2].shift, 2'b01);
        chk("add_aluop", trace[3].st.aluop, 0);
        chk("add_writenum", trace[4].st.writenum, 2);

        run(0, 16'hA900, 1'b0);
        loads_seen = '0; write_seen = '0;
        foreach (trace[i]) begin
            loads_seen[i] = trace[i].st.loads;
            write_seen[i] = trace[i].st.write;
        end
        chk("cmp_len", trace.size(), 4);
        chk("cmp_loads", loads_seen, 8'b0000_1000);
        chk("cmp_write", write_seen, 0);

        run(0, 16'hE000, 1'b0);
        chk("ill_len", trace.size(), 1);
        chk("ill_flag", act[0].illegal, 1);
        chk("ill_count", act[0].count, 3);
        run(0, 16'hD007, 1'b0);
        chk("ill_clear", trace[0].illegal, 0);
        chk("ill_next_count", act[0].count, 4);

        run(0, 16'hB8A0, 1'b1);
        chk("mvn_len", trace.size(), 4);
        chk("mvn_ir_held", trace[3].sximm8, 16'hFFA0);
        chk("mvn_asel", trace[2].st.asel, 1);
        chk("mvn_aluop", trace[2].st.aluop, 2'b11);
        chk("mvn_writenum", trace[3].st.writenum, 5);

        run(1, 16'hD0F0, 1'b0);
        chk("fast_len", trace.size(), 1);
        chk("fast_write", trace[0].st.write, 1);
        chk("fast_sximm8", trace[0].sximm8, 16'hFFF0);

        @(negedge clk); #1;
        load[1] = 1'b1; in_w[1] = 16'hA148; s[1] = 1'b1;
        @(negedge clk); #1;
        load[1] = 1'b0; s[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_getb", act[1].st.loadb, 1);
        #1 reset[1] = 1'b1;
        @(negedge clk);
        chk("abort_w", act[1].st.w, 1);
        chk("abort_write", act[1].st.write, 0);
        chk("abort_count", act[1].count, 0);
        #1 reset[1] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run(1, 16'hD007, 1'b0);
            if (i == 2) chk("wrap_three", act[1].count, 3);
        end
        chk("wrap_zero", act[1].count, 0);

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                reset[d] = ($urandom_range(0, 99) == 0);
                load[d]  = ($urandom_range(0, 3) == 0);
                s[d]     = ($urandom_range(0, 2) == 0);
                in_w[d]  = rand_word();
            end
        end
        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
